// File: rtl/acumulador_pkg.sv
// Shared opcodes and FSM encoding for the
// parametrised accumulator.
package acumulador_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_LOAD  = 2'b10,
    OP_CLEAR = 2'b11
  } op_t;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fa_n_sat.sv
// Signed add/sub on WIDTH bits with overflow
// detection and optional clamp to the range limits.
module fa_n_sat #(
  parameter int WIDTH    = 16,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  output logic [WIDTH-1:0] S,
  output logic             Ovf
);

  localparam logic [WIDTH-1:0] MAXV =
    {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINV =
    {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH:0] a_x;
  logic [WIDTH:0] b_x;
  logic [WIDTH:0] ext;

  assign a_x = {A[WIDTH-1], A};
  assign b_x = {B[WIDTH-1], B};
  assign ext = Sub ? (a_x - b_x) : (a_x + b_x);

  // exact sign lives in bit WIDTH
  assign Ovf = ext[WIDTH] ^ ext[WIDTH-1];

  always_comb begin
    S = ext[WIDTH-1:0];
    if (SATURATE != 0 && Ovf)
      S = ext[WIDTH] ? MINV : MAXV;
  end

endmodule

// File: rtl/acumulador_parametrizado.sv
// Start/Busy/Done sequenced accumulator: capture B,
// execute on A, present result with a Done pulse.
module acumulador_parametrizado
  import acumulador_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int SATURATE = 0,
  parameter int CNT_W    = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] DataIN,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] DataOut,
  output logic             Overflow,
  output logic [CNT_W-1:0] Count
);

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] sum;
  logic             sum_ovf;

  fa_n_sat #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_fa (
    .A   (a_q),
    .B   (b_q),
    .Sub (op_q == OP_SUB),
    .S   (sum),
    .Ovf (sum_ovf)
  );

  always_ff @(posedge Clock) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (Start) state_d = S_EXEC;
      S_EXEC:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    Busy = 1'b0;
    Done = 1'b0;
    unique case (1'b1)
      state_q == S_EXEC: Busy = 1'b1;
      state_q == S_DONE: begin
        Busy = 1'b1;
        Done = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    b_d   = b_q;
    op_d  = op_q;
    a_d   = a_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (state_q == S_IDLE && Start) begin
      b_d  = DataIN;
      op_d = op_t'(Op);
    end
    if (state_q == S_EXEC) begin
      unique case (op_q)
        OP_ADD, OP_SUB: begin
          a_d   = sum;
          ovf_d = ovf_q | sum_ovf;
          // counter sticks at all-ones
          if (!(&cnt_q))
            cnt_d = cnt_q + CNT_W'(1);
        end
        OP_LOAD: begin
          a_d   = b_q;
          cnt_d = CNT_W'(1);
        end
        OP_CLEAR: begin
          a_d   = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      b_q   <= '0;
      op_q  <= OP_ADD;
      a_q   <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      b_q   <= b_d;
      op_q  <= op_d;
      a_q   <= a_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign DataOut  = a_q;
  assign Overflow = ovf_q;
  assign Count    = cnt_q;

endmodule

// File: tb/tb_acumulador_parametrizado.sv
// Directed bench: wrap, saturate and narrow-counter
// instances driven side by side.
module tb_acumulador_parametrizado;

  logic        clk;
  logic        rst;
  logic        st   [3];
  logic [1:0]  op   [3];
  logic [15:0] din  [3];
  logic        busy [3];
  logic        done [3];
  logic [15:0] dout [3];
  logic        ovf  [3];
  logic [7:0]  cnt0, cnt1;
  logic [1:0]  cnt2;

  int vectors;
  int miscompares;
  int pulses;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  acumulador_parametrizado #(
    .WIDTH(16), .SATURATE(0), .CNT_W(8)
  ) u0 (
    .Clock(clk), .Reset(rst), .Start(st[0]),
    .Op(op[0]), .DataIN(din[0]), .Busy(busy[0]),
    .Done(done[0]), .DataOut(dout[0]),
    .Overflow(ovf[0]), .Count(cnt0)
  );

  acumulador_parametrizado #(
    .WIDTH(16), .SATURATE(1), .CNT_W(8)
  ) u1 (
    .Clock(clk), .Reset(rst), .Start(st[1]),
    .Op(op[1]), .DataIN(din[1]), .Busy(busy[1]),
    .Done(done[1]), .DataOut(dout[1]),
    .Overflow(ovf[1]), .Count(cnt1)
  );

  acumulador_parametrizado #(
    .WIDTH(16), .SATURATE(0), .CNT_W(2)
  ) u2 (
    .Clock(clk), .Reset(rst), .Start(st[2]),
    .Op(op[2]), .DataIN(din[2]), .Busy(busy[2]),
    .Done(done[2]), .DataOut(dout[2]),
    .Overflow(ovf[2]), .Count(cnt2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int i);
    case (i)
      0:       return 32'(cnt0);
      1:       return 32'(cnt1);
      default: return 32'(cnt2);
    endcase
  endfunction

  // one full handshake; inputs scrambled after accept
  task automatic do_op(input int i,
                       input logic [1:0] o,
                       input logic [15:0] d);
    @(negedge clk);
    st[i]  = 1'b1;
    op[i]  = o;
    din[i] = d;
    @(posedge clk);
    #1;
    st[i]  = 1'b0;
    op[i]  = ~o;
    din[i] = 16'hA5C3;
    @(negedge clk);
    chk("exec_busy", 32'(busy[i]), 1);
    chk("exec_done", 32'(done[i]), 0);
    @(posedge clk);
    @(negedge clk);
    chk("done_hi", 32'(done[i]), 1);
    @(posedge clk);
    @(negedge clk);
    chk("done_lo", 32'(done[i]), 0);
    chk("idle_busy", 32'(busy[i]), 0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      st[i]  = 1'b0;
      op[i]  = 2'b00;
      din[i] = 16'h0000;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_dout", 32'(dout[0]), 0);
    chk("rst_busy", 32'(busy[0]), 0);
    chk("rst_done", 32'(done[0]), 0);
    chk("rst_ovf",  32'(ovf[0]), 0);
    chk("rst_cnt",  cnt_of(0), 0);
    rst = 1'b0;

    // basic add
    do_op(0, 2'b00, 16'h0005);
    chk("add5", 32'(dout[0]), 32'h0005);
    do_op(0, 2'b00, 16'h0003);
    chk("add3",     32'(dout[0]), 32'h0008);
    chk("add_cnt",  cnt_of(0), 2);
    chk("add_ovf",  32'(ovf[0]), 0);

    // wrap-around overflow
    do_op(0, 2'b10, 16'h7FFF);
    chk("ld_cnt", cnt_of(0), 1);
    do_op(0, 2'b00, 16'h0001);
    chk("wrap",     32'(dout[0]), 32'h8000);
    chk("wrap_ovf", 32'(ovf[0]), 1);
    do_op(0, 2'b00, 16'h0001);
    chk("wrap2",    32'(dout[0]), 32'h8001);
    chk("sticky",   32'(ovf[0]), 1);
    chk("wrap_cnt", cnt_of(0), 3);
    do_op(0, 2'b01, 16'h0003);
    chk("sub",      32'(dout[0]), 32'h7FFE);

    // saturating instance
    do_op(1, 2'b10, 16'h8000);
    chk("sat_ld_ovf", 32'(ovf[1]), 0);
    do_op(1, 2'b01, 16'h0001);
    chk("sat_neg",     32'(dout[1]), 32'h8000);
    chk("sat_neg_ovf", 32'(ovf[1]), 1);
    do_op(1, 2'b10, 16'h7FF0);
    chk("sat_ld_keep", 32'(ovf[1]), 1);
    do_op(1, 2'b00, 16'h0100);
    chk("sat_pos", 32'(dout[1]), 32'h7FFF);
    do_op(1, 2'b11, 16'h1234);
    chk("sat_clr_ovf", 32'(ovf[1]), 0);

    // Start held high: one op per three cycles
    do_op(0, 2'b11, 16'h0000);
    chk("clr", 32'(dout[0]), 0);
    pulses = 0;
    @(negedge clk);
    st[0]  = 1'b1;
    op[0]  = 2'b00;
    din[0] = 16'h0001;
    for (int c = 0; c < 9; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done[0]) pulses++;
      if (c == 0) din[0] = 16'h0100;
      if (c == 1) din[0] = 16'h0001;
    end
    st[0] = 1'b0;
    chk("held_pulses", 32'(pulses), 3);
    chk("held_dout",   32'(dout[0]), 32'h0003);
    chk("held_cnt",    cnt_of(0), 3);
    repeat (3) @(negedge clk);
    chk("held_stop", 32'(dout[0]), 32'h0003);

    // reset aborts an op in EXEC
    @(negedge clk);
    st[0]  = 1'b1;
    op[0]  = 2'b00;
    din[0] = 16'h0005;
    @(posedge clk);
    #1;
    st[0] = 1'b0;
    @(negedge clk);
    chk("abort_busy0", 32'(busy[0]), 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_dout", 32'(dout[0]), 0);
    chk("abort_busy", 32'(busy[0]), 0);
    chk("abort_cnt",  cnt_of(0), 0);
    chk("abort_done", 32'(done[0]), 0);
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (done[0]) pulses++;
    end
    chk("abort_nodone", 32'(pulses), 0);

    // narrow counter saturates
    do_op(2, 2'b10, 16'h7FFF);
    chk("n_ld_cnt", cnt_of(2), 1);
    do_op(2, 2'b00, 16'h0001);
    repeat (4) do_op(2, 2'b00, 16'h0000);
    chk("n_cnt_sat", cnt_of(2), 3);
    chk("n_dout",    32'(dout[2]), 32'h8000);
    chk("n_ovf",     32'(ovf[2]), 1);
    do_op(2, 2'b11, 16'h5555);
    chk("n_clr_dout", 32'(dout[2]), 0);
    chk("n_clr_ovf",  32'(ovf[2]), 0);
    chk("n_clr_cnt",  cnt_of(2), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
